master_port_mux: RTL

MASTER_PORT_MUX -- requirements
Module: master_port_mux

---
 rtl/xbar_pkg.sv | 19 +
 rtl/stream_fifo2.sv | 53 +++++
 rtl/master_port_mux.sv | 105 ++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar types and width helpers.
// Holds the port FSM state enum and index width functions.
package xbar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Clamped to 1 so a single-stream build still gets an index field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int dest_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry stream buffer with registered full/empty flags.
// Ports: push_i/data_i write, pop_i/data_o read, full_o, empty_o.
module stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign data_o  = mem_q[rd_q];

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
    end
    wr_d  = wr_q ^ do_push;
    rd_d  = rd_q ^ do_pop;
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/master_port_mux.sv
// Per-master-port mux: locks onto the granted slave for one packet
// and buffers beats in a 2-entry FIFO toward the master port.
module master_port_mux
  import xbar_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int PORT_ID      = 0,
  localparam int T_ID___WIDTH = id_width(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [T_ID___WIDTH-1:0] grant_i,
  input  logic                    grant_valid_i,
  output logic                    done_o,
  input  logic [S_DATA_COUNT-1:0]
               [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic [S_DATA_COUNT-1:0]
               [T_DEST_WIDTH-1:0] s_dest_i,
  output logic [S_DATA_COUNT-1:0] s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_valid_o,
  output logic                    m_last_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  input  logic                    m_ready_i
);

  localparam int FW = T_DATA_WIDTH + 1 + T_ID___WIDTH;

  state_e                  state_q, state_d;
  logic [T_ID___WIDTH-1:0] sel_q, sel_d;
  logic                    done_q, done_d;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    accept;
  logic [FW-1:0]           fifo_din;
  logic [FW-1:0]           fifo_dout;

  // Ready depends only on registered full, never on m_ready_i.
  always_comb begin
    s_ready_o = '0;
    if (state_q == BUSY && !fifo_full &&
        s_dest_i[sel_q] == T_DEST_WIDTH'(PORT_ID)) begin
      s_ready_o[sel_q] = 1'b1;
    end
  end

  assign accept   = s_valid_i[sel_q] && s_ready_o[sel_q];
  assign fifo_din = {s_data_i[sel_q], s_last_i[sel_q], sel_q};

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid_i) begin
          sel_d   = grant_i;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && s_last_i[sel_q]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  assign done_o    = done_q;
  assign m_valid_o = !fifo_empty;

  stream_fifo2 #(
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (fifo_din),
    .pop_i   (m_valid_o && m_ready_i),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {m_data_o, m_last_o, m_id_o} = fifo_dout;

endmodule
